// File: rtl/chronometer_multimode.sv
// rtl/chronometer_multimode.sv - min:sec up/down stopwatch core with 1 s prescaler; lap capture built only when CHRONO_LAP_EN is defined
module chronometer_multimode #(
    parameter int CLK_DIV = 100_000_000,
    parameter int MIN_W   = 8
) (
    input  logic             i_sys_clk,
    input  logic             i_hw_reset_n,
    input  logic             i_cmd_start,
    input  logic             i_cmd_stop,
    input  logic             i_cmd_reset,
    input  logic             i_mode_down,
    input  logic             i_load_valid,
    input  logic [MIN_W-1:0] i_load_min,
    input  logic [5:0]       i_load_sec,
    input  logic             i_cmd_lap,
    output logic [MIN_W-1:0] o_val_min,
    output logic [5:0]       o_val_sec,
    output logic [1:0]       o_fsm_state,
    output logic             o_expired,
    output logic [MIN_W-1:0] o_lap_min,
    output logic [5:0]       o_lap_sec,
    output logic             o_lap_valid
);

    localparam int               PW      = $clog2(CLK_DIV);
    localparam logic [PW-1:0]    PS_LAST = PW'(CLK_DIV - 1);
    localparam logic [MIN_W-1:0] MIN_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ps, ps_nxt;
    logic [MIN_W-1:0] cnt_min, min_nxt;
    logic [5:0]       cnt_sec, sec_nxt;
    logic             mode, mode_nxt;
    logic             expired, expired_nxt;
    logic             at_zero;

    assign at_zero = (cnt_min == '0) && (cnt_sec == 6'd0);

    always_ff @(posedge i_sys_clk or negedge i_hw_reset_n) begin
        if (!i_hw_reset_n) begin
            state   <= ST_IDLE;
            ps      <= '0;
            cnt_min <= '0;
            cnt_sec <= 6'd0;
            mode    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            ps      <= ps_nxt;
            cnt_min <= min_nxt;
            cnt_sec <= sec_nxt;
            mode    <= mode_nxt;
            expired <= expired_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ps_nxt      = ps;
        min_nxt     = cnt_min;
        sec_nxt     = cnt_sec;
        mode_nxt    = mode;
        expired_nxt = 1'b0;
        if (i_cmd_reset) begin
            state_nxt = ST_IDLE;
            ps_nxt    = '0;
            min_nxt   = '0;
            sec_nxt   = 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!i_cmd_stop && i_cmd_start) begin
                        if (!(i_mode_down && at_zero)) begin
                            state_nxt = ST_RUN;
                            mode_nxt  = i_mode_down;
                            ps_nxt    = '0;
                        end
                    end else if (!i_cmd_stop && i_load_valid) begin
                        min_nxt = i_load_min;
                        sec_nxt = (i_load_sec > 6'd59) ? 6'd59 : i_load_sec;
                    end
                end
                ST_RUN: begin
                    // A stop on the tick cycle suppresses the tick and keeps the prescaler at its last value,
                    // so the resumed second replays that tick immediately.
                    if (i_cmd_stop) begin
                        state_nxt = ST_PAUSED;
                    end else if (ps != PS_LAST) begin
                        ps_nxt = ps + 1'b1;
                    end else begin
                        ps_nxt = '0;
                        if (!mode) begin
                            if (cnt_min == MIN_MAX && cnt_sec == 6'd59) begin
                                state_nxt   = ST_DONE;
                                expired_nxt = 1'b1;
                            end else if (cnt_sec == 6'd59) begin
                                sec_nxt = 6'd0;
                                min_nxt = cnt_min + 1'b1;
                            end else begin
                                sec_nxt = cnt_sec + 6'd1;
                            end
                        end else if (at_zero) begin
                            state_nxt   = ST_DONE;
                            expired_nxt = 1'b1;
                        end else if (cnt_sec == 6'd0) begin
                            sec_nxt = 6'd59;
                            min_nxt = cnt_min - 1'b1;
                        end else begin
                            sec_nxt = cnt_sec - 6'd1;
                            if (cnt_min == '0 && cnt_sec == 6'd1) begin
                                state_nxt   = ST_DONE;
                                expired_nxt = 1'b1;
                            end
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!i_cmd_stop && i_cmd_start) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_DONE;
                end
            endcase
        end
    end

    assign o_val_min   = cnt_min;
    assign o_val_sec   = cnt_sec;
    assign o_fsm_state = state;
    assign o_expired   = expired;

`ifdef CHRONO_LAP_EN
    logic [MIN_W-1:0] lap_min;
    logic [5:0]       lap_sec;
    logic             lap_valid;
    logic             lap_take;

    // Registers sampled here are the pre-tick values, so a lap on a tick cycle reports the old time.
    assign lap_take = i_cmd_lap && !i_cmd_stop && !i_cmd_start && !i_load_valid &&
                      (state == ST_RUN || state == ST_PAUSED);

    always_ff @(posedge i_sys_clk or negedge i_hw_reset_n) begin
        if (!i_hw_reset_n) begin
            lap_min   <= '0;
            lap_sec   <= 6'd0;
            lap_valid <= 1'b0;
        end else if (i_cmd_reset) begin
            lap_valid <= 1'b0;
        end else if (lap_take) begin
            lap_min   <= cnt_min;
            lap_sec   <= cnt_sec;
            lap_valid <= 1'b1;
        end
    end

    assign o_lap_min   = lap_min;
    assign o_lap_sec   = lap_sec;
    assign o_lap_valid = lap_valid;
`else
    logic unused_lap;
    assign unused_lap  = i_cmd_lap;
    assign o_lap_min   = '0;
    assign o_lap_sec   = 6'd0;
    assign o_lap_valid = 1'b0;
`endif

endmodule

// File: doc/chronometer_multimode.md
Name: chronometer_multimode

Overview:
Parametrised successor to the chronometer_main stopwatch core. Counts minutes:seconds up, or down from a loaded preset, using an internal prescaler of the system clock. Adds lap capture, a terminal-count flag and saturation handling. Sits between the button/command decoder and the display or register interface.

Parameters:
CLK_DIV, 100_000_000, system clock cycles per 1 s tick (>=2; benches use 4)
MIN_W, 8, minute counter width; maximum minute value is 2^MIN_W-1

Ports:
i_sys_clk  in  1  system clock, all logic on rising edge
i_hw_reset_n  in  1  asynchronous active-low reset
i_cmd_start  in  1  start/resume, single-cycle pulse
i_cmd_stop  in  1  pause, single-cycle pulse
i_cmd_reset  in  1  synchronous soft clear, single-cycle pulse
i_mode_down  in  1  0=count up, 1=count down; sampled only on an accepted start from IDLE
i_load_valid  in  1  load preset; honoured only in IDLE
i_load_min  in  MIN_W  preset minutes
i_load_sec  in  6  preset seconds; values >59 are clamped to 59
i_cmd_lap  in  1  capture current time (feature-gated)
o_val_min  out  MIN_W  current minutes
o_val_sec  out  6  current seconds, 0..59
o_fsm_state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 DONE
o_expired  out  1  one-cycle pulse on entry to DONE
o_lap_min  out  MIN_W  captured minutes (feature-gated)
o_lap_sec  out  6  captured seconds (feature-gated)
o_lap_valid  out  1  high from the first capture until reset (feature-gated)

Behaviour:
- Async reset: state IDLE, counters 0, prescaler 0, latched mode 0 (up), o_expired 0, lap outputs 0.
- Command priority within one cycle: reset > stop > start > load > lap. A lower-priority command in the same cycle is ignored.
- i_cmd_reset, any state: next cycle IDLE, counters 0, prescaler 0, o_lap_valid 0. The preset is not retained.
- IDLE:
  - i_load_valid writes the counters.
  - i_cmd_start -> RUN and latches i_mode_down.
  - A start in down mode with 00:00 is ignored; the block stays in IDLE.
- RUN:
  - Prescaler counts 0..CLK_DIV-1. The tick fires in the cycle the prescaler equals CLK_DIV-1; the prescaler then wraps to 0.
  - First tick occurs CLK_DIV cycles after the start is accepted; counters update on the edge after the tick cycle.
  - i_cmd_stop -> PAUSED.
  - i_cmd_start and i_load_valid are ignored.
- PAUSED:
  - Counters and prescaler hold. Prescaler is not cleared, so resumed timing stays exact to the cycle.
  - i_cmd_start -> RUN. Mode is not re-sampled.
- Up count, per tick:
  - sec 59 -> 0 with min+1; otherwise sec+1.
  - At max_min:59 the next tick holds the value, goes to DONE and pulses o_expired.
- Down count, per tick:
  - sec 0 -> 59 with min-1; otherwise sec-1.
  - When the value becomes 00:00 -> DONE and o_expired pulses in the same cycle the counters show 00:00.
- DONE: counters frozen; start, stop and load ignored; only i_cmd_reset leaves.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
CHRONO_LAP_EN
- Defined:
  - i_cmd_lap in RUN or PAUSED copies the current min/sec into the lap registers and sets o_lap_valid.
  - A lap in the same cycle as a tick captures the pre-tick value.
  - A lap in IDLE or DONE is ignored.
- Undefined: i_cmd_lap is ignored; lap outputs are tied to 0; no lap registers are synthesised.

Test Plan:
- CLK_DIV=4: reset, start, run 250 cycles -> 01:02, state 01; stop, wait 40 cycles -> value unchanged, state 10.
- Up count from preset 00:58 -> after 2 ticks reads 01:00 (seconds wrap carries into minutes).
- Down mode, load 00:02, start -> 00:01 after 4 cycles, 00:00 after 8 cycles; state 11 and o_expired high for exactly 1 cycle; a later start is ignored.
- Down start at 00:00 -> stays IDLE, no tick. Load with sec=63 -> reads 59.
- Pause 2 cycles into a second, resume -> next tick 2 cycles after resume. Stop and start in the same cycle -> PAUSED.
- CHRONO_LAP_EN: lap at 00:03 while running -> o_lap 00:03, o_lap_valid 1, counting continues. Soft reset -> o_lap_valid 0, IDLE, 00:00. Async reset mid-RUN -> all outputs 0 immediately.
